// File: rtl/demux3_pkg.sv
// Shared channel encoding for the mux3 / demux3 family: channel indices, slot states,
// and the S1/S0 select decode so selector and distributor can never disagree.
package demux3_pkg;

   localparam logic [1:0] CH0 = 2'd0;
   localparam logic [1:0] CH1 = 2'd1;
   localparam logic [1:0] CH2 = 2'd2;
   localparam int         NCH = 3;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // S0 is a don't-care once S1 is set, so an X there never reaches the result.
   function automatic logic [1:0] decode(input logic s1, input logic s0);
      if (s1) begin
         return CH2;
      end
      return s0 ? CH1 : CH0;
   endfunction

endpackage

// File: rtl/demux3_slot.sv
// One-deep output holding register with valid flag and saturating accept counter; load visible after 1 edge.
// Backpressure: free while empty or draining, so a load and a drain may share an edge without a bubble.
module demux3_slot
   import demux3_pkg::*;
#(
   parameter int W  = 1,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [W-1:0]  d,
   input  logic          rdy,
   output logic [W-1:0]  q,
   output logic          vld,
   output logic [CW-1:0] cnt,
   output logic          free
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   slot_state_t   r_state;
   logic [W-1:0]  r_q;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SLOT_EMPTY;
         r_q     <= '0;
         r_cnt   <= '0;
      end else begin
         if (r_state == SLOT_EMPTY) begin
            if (load) begin
               r_state <= SLOT_FULL;
            end
         end else begin
            if (rdy && !load) begin
               r_state <= SLOT_EMPTY;
            end
         end

         // Data only moves on a load, so a stalled or drained word stays put.
         if (load) begin
            r_q <= d;
            if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign q    = r_q;
   assign vld  = (r_state == SLOT_FULL);
   assign cnt  = r_cnt;
   assign free = !vld || rdy;

endmodule

// File: rtl/demux3_reg.sv
// Registered 1-to-3 stream demultiplexer steered by S1/S0; 1-cycle latency, 1 word/cycle per channel.
// Backpressure: in_ready reflects only the targeted slot's free flag, never in_valid.
module demux3_reg
   import demux3_pkg::*;
#(
   parameter int W  = 1,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  In,
   input  logic          S0,
   input  logic          S1,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  Out0,
   output logic [W-1:0]  Out1,
   output logic [W-1:0]  Out2,
   output logic [2:0]    out_valid,
   input  logic [2:0]    out_ready,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2
);

   logic [1:0]    w_sel;
   logic          w_ready;
   logic [2:0]    w_free;
   logic [2:0]    w_load;
   logic [W-1:0]  w_q   [NCH];
   logic [CW-1:0] w_cnt [NCH];

   assign w_sel = decode(S1, S0);

   always_comb begin
      w_ready = 1'b0;
      case (w_sel)
         CH0:     w_ready = w_free[0];
         CH1:     w_ready = w_free[1];
         CH2:     w_ready = w_free[2];
         default: w_ready = 1'b0;
      endcase
   end

   assign in_ready = w_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_slot
      assign w_load[k] = in_valid && w_ready && (w_sel == 2'(k));

      demux3_slot #(
         .W  (W),
         .CW (CW)
      ) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (w_load[k]),
         .d     (In),
         .rdy   (out_ready[k]),
         .q     (w_q[k]),
         .vld   (out_valid[k]),
         .cnt   (w_cnt[k]),
         .free  (w_free[k])
      );
   end

   assign Out0 = w_q[0];
   assign Out1 = w_q[1];
   assign Out2 = w_q[2];
   assign cnt0 = w_cnt[0];
   assign cnt1 = w_cnt[1];
   assign cnt2 = w_cnt[2];

endmodule
